// File: rtl/ir_scan_scheduler_pkg.sv
// Shared types and helpers for the IR line-sensor scan scheduler.
package ir_scan_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHARGE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_NEXT    = 2'd3
  } scan_state_e;

  localparam int SYNC_STAGES = 2;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ir_sync2.sv
// Per-bit multi-flop synchronizer for the raw sensor inputs.
// A bit whose sensor is being driven is forced high through every stage: the
// driven node reads high, and this keeps a stale low from an earlier channel
// from reaching the measurement before the real discharge can be seen.
module ir_sync2
  import ir_scan_scheduler_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] preset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [SYNC_STAGES-1:0][W-1:0] stg_q;
  logic [SYNC_STAGES-1:0][W-1:0] stg_d;

  // Shift chain with the drive preset folded into every stage.
  always_comb begin
    stg_d    = stg_q;
    stg_d[0] = d_i | preset_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      stg_d[s] = stg_q[s-1] | preset_i;
    end
  end

  // Synchronizer flops, cleared by the synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign q_o = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/ir_scan_scheduler.sv
// Time-multiplexes one charge/discharge timer across NUM_SENSORS reflective IR
// sensors. Each channel is charged, released and timed; a full scan is
// collected in shadow registers and published atomically with scan_done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no scan running, all drives low
// CHARGE  | drive of active channel high for CHARGE_CYCLES cycles
// MEASURE | drive released, count until synced input low or TIMEOUT
// NEXT    | advance channel, or publish results after the last one
module ir_scan_scheduler
  import ir_scan_scheduler_pkg::*;
#(
  parameter int NUM_SENSORS   = 4,
  parameter int CHARGE_CYCLES = 4,
  parameter int TIMEOUT       = 2000,
  parameter int CNT_W         = 18
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [NUM_SENSORS-1:0]                 sensor_in,
  output logic [NUM_SENSORS-1:0]                 sensor_drive,
  output logic [NUM_SENSORS*CNT_W-1:0]           time_bus,
  output logic [NUM_SENSORS-1:0]                 black,
  output logic                                   scan_done,
  output logic                                   busy,
  output logic [clog2_min1(NUM_SENSORS)-1:0]     active_ch
);

  localparam int CH_W = clog2_min1(NUM_SENSORS);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_SENSORS - 1);
  localparam logic [CNT_W-1:0] CHG_LAST = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);

  scan_state_e st_q, st_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_SENSORS-1:0][CNT_W-1:0] sh_time_q, sh_time_d;
  logic [NUM_SENSORS-1:0]            sh_black_q, sh_black_d;
  logic [NUM_SENSORS-1:0][CNT_W-1:0] pub_time_q, pub_time_d;
  logic [NUM_SENSORS-1:0]            pub_black_q, pub_black_d;
  logic                              done_q, done_d;

  logic [NUM_SENSORS-1:0] drive;
  logic [NUM_SENSORS-1:0] sens_sync;

  ir_sync2 #(
    .W (NUM_SENSORS)
  ) u_sync (
    .clk_i    (clock),
    .rst_ni   (reset),
    .preset_i (drive),
    .d_i      (sensor_in),
    .q_o      (sens_sync)
  );

  // One-hot drive on the active channel while charging, otherwise all low.
  always_comb begin
    drive = '0;
    if (st_q == ST_CHARGE) drive[ch_q] = 1'b1;
  end

  // Next-state logic: sequencing, shared counter, shadow capture, publish.
  always_comb begin
    st_d        = st_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    sh_time_d   = sh_time_q;
    sh_black_d  = sh_black_q;
    pub_time_d  = pub_time_q;
    pub_black_d = pub_black_q;
    done_d      = 1'b0;

    unique case (st_q)
      ST_IDLE: begin
        if (enable) begin
          st_d  = ST_CHARGE;
          ch_d  = '0;
          cnt_d = '0;
        end
      end

      ST_CHARGE: begin
        if (cnt_q == CHG_LAST) begin
          st_d  = ST_MEASURE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_MEASURE: begin
        // A low input wins over a timeout landing in the same cycle.
        if (!sens_sync[ch_q]) begin
          sh_time_d[ch_q]  = cnt_q;
          sh_black_d[ch_q] = 1'b0;
          st_d             = ST_NEXT;
        end else if (cnt_q == TO_VAL) begin
          sh_time_d[ch_q]  = TO_VAL;
          sh_black_d[ch_q] = 1'b1;
          st_d             = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_NEXT: begin
        cnt_d = '0;
        if (ch_q != LAST_CH) begin
          ch_d = ch_q + 1'b1;
          st_d = ST_CHARGE;
        end else begin
          // Whole scan is in the shadow; publish it in one step.
          pub_time_d  = sh_time_q;
          pub_black_d = sh_black_q;
          done_d      = 1'b1;
          ch_d        = '0;
          st_d        = enable ? ST_CHARGE : ST_IDLE;
        end
      end

      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, shadow and published result registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      st_q        <= ST_IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      sh_time_q   <= '0;
      sh_black_q  <= '0;
      pub_time_q  <= '0;
      pub_black_q <= '0;
      done_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      sh_time_q   <= sh_time_d;
      sh_black_q  <= sh_black_d;
      pub_time_q  <= pub_time_d;
      pub_black_q <= pub_black_d;
      done_q      <= done_d;
    end
  end

  assign sensor_drive = drive;
  assign time_bus     = pub_time_q;
  assign black        = pub_black_q;
  assign scan_done    = done_q;
  assign busy         = (st_q != ST_IDLE);
  assign active_ch    = ch_q;

endmodule

// File: tb/tb_ir_scan_scheduler.sv
// Bench for ir_scan_scheduler: a sensor model that falls a chosen number of
// cycles after drive release, and a reference that predicts each published
// scan (times, black flags, scan period) from those delays.
module tb_ir_scan_scheduler;

  localparam int N  = 4;
  localparam int CC = 4;
  localparam int TO = 20;
  localparam int CW = 18;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    sensor_in;
  logic [N-1:0]    sensor_drive;
  logic [N*CW-1:0] time_bus;
  logic [N-1:0]    black;
  logic            scan_done;
  logic            busy;
  logic [1:0]      active_ch;

  ir_scan_scheduler #(
    .NUM_SENSORS   (N),
    .CHARGE_CYCLES (CC),
    .TIMEOUT       (TO),
    .CNT_W         (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sensor_in    (sensor_in),
    .sensor_drive (sensor_drive),
    .time_bus     (time_bus),
    .black        (black),
    .scan_done    (scan_done),
    .busy         (busy),
    .active_ch    (active_ch)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sensor model state
  int        dly[N];
  int        since[N];
  int        hi_cnt[N];
  int        dlat[N];
  logic [N-1:0] prv_drv;
  bit        held0;
  bit        rnd_mut;

  function automatic int exp_t(input int d);
    return (d + 2 > TO) ? TO : d + 2;
  endfunction

  function automatic logic exp_blk(input int d);
    return (d + 2 > TO);
  endfunction

  // Called just after each rising edge: model the sensor nodes.
  task automatic update_sensors();
    if (rnd_mut && $urandom_range(0, 7) == 0) begin
      int k;
      k = $urandom_range(0, N - 1);
      if (sensor_drive[k] || !busy || int'(active_ch) != k)
        dly[k] = $urandom_range(0, 25);
    end
    for (int k = 0; k < N; k++) begin
      if (sensor_drive[k]) begin
        since[k] = 0;
        hi_cnt[k]++;
      end else if (prv_drv[k]) begin
        chk($sformatf("charge_len%0d", k), 64'(hi_cnt[k]), 64'(CC));
        hi_cnt[k] = 0;
        since[k]  = 0;
        dlat[k]   = held0 ? 0 : dly[k];
      end else if (since[k] < 1000000) begin
        since[k]++;
      end
      sensor_in[k] = held0 ? 1'b0 : (sensor_drive[k] || since[k] < dly[k]);
    end
    prv_drv = sensor_drive;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    update_sensors();
  endtask

  task automatic wait_done(input int bound);
    int t;
    t = 0;
    do begin
      step();
      t++;
    end while (!scan_done && t < bound);
    chk("scan_done_seen", 64'(scan_done), 64'(1));
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  task automatic chk_times(input string tag, input int t0, input int t1, input int t2, input int t3);
    int e[N];
    e[0] = t0; e[1] = t1; e[2] = t2; e[3] = t3;
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_t%0d", tag, k), 64'(time_bus[k*CW +: CW]), 64'(e[k]));
  endtask

  // Monitor: one-hot drive, result stability, scan results and period.
  int        cyc = 0;
  int        scan_start = -1;
  int        sum_per;
  logic      rst_smp;
  logic      d0_prev = 1'b0;
  logic [N*CW-1:0] tb_prev;
  logic [N-1:0]    bl_prev;

  initial begin
    forever begin
      @(posedge clock);
      rst_smp = reset;
      @(negedge clock);
      cyc++;
      chk("onehot", 64'($countones(sensor_drive) <= 1), 64'(1));
      if (scan_done) begin
        sum_per = 0;
        for (int k = 0; k < N; k++) begin
          chk($sformatf("time%0d", k), 64'(time_bus[k*CW +: CW]), 64'(exp_t(dlat[k])));
          chk($sformatf("black%0d", k), 64'(black[k]), 64'(exp_blk(dlat[k])));
          sum_per += CC + exp_t(dlat[k]) + 2;
        end
        if (scan_start >= 0) chk("scan_period", 64'(cyc - scan_start), 64'(sum_per));
      end else if (rst_smp === 1'b1) begin
        chk("stable", 64'({time_bus, black} === {tb_prev, bl_prev}), 64'(1));
      end
      if (rst_smp !== 1'b1) scan_start = -1;
      if (sensor_drive[0] && !d0_prev) scan_start = cyc;
      d0_prev = sensor_drive[0];
      tb_prev = time_bus;
      bl_prev = black;
    end
  end

  initial begin
    int extra;
    int t;
    reset     = 1'b0;
    enable    = 1'b0;
    sensor_in = '0;
    held0     = 1'b0;
    rnd_mut   = 1'b0;
    prv_drv   = '0;
    for (int k = 0; k < N; k++) begin
      dly[k] = 0; since[k] = 1000000; hi_cnt[k] = 0; dlat[k] = 0;
    end

    repeat (3) step();
    chk("rst_drive", 64'(sensor_drive), 64'(0));
    chk("rst_time", 64'(time_bus != '0), 64'(0));
    chk("rst_black", 64'(black), 64'(0));
    chk("rst_done", 64'(scan_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ch", 64'(active_ch), 64'(0));
    reset = 1'b1;
    step();

    // Sensors held low: every channel reports synchronizer latency only.
    held0  = 1'b1;
    enable = 1'b1;
    step();
    chk("enable_to_drive", 64'(sensor_drive), 64'(1));
    repeat (3) wait_done(200);
    chk_times("held0", 2, 2, 2, 2);
    chk("held0_black", 64'(black), 64'(0));

    // Sensors held high: every channel times out.
    held0 = 1'b0;
    set_dly(1000, 1000, 1000, 1000);
    repeat (2) wait_done(400);
    chk_times("held1", 20, 20, 20, 20);
    chk("held1_black", 64'(black), 64'(4'b1111));

    // Mixed delays.
    set_dly(0, 5, 10, 30);
    repeat (2) wait_done(400);
    chk_times("mixed", 2, 7, 12, 20);
    chk("mixed_black", 64'(black), 64'(4'b1000));

    // Around the timeout boundary.
    set_dly(18, 19, 17, 0);
    repeat (2) wait_done(400);
    chk_times("edge", 20, 20, 19, 2);
    chk("edge_black", 64'(black), 64'(4'b0010));

    // Random delays, changed mid-scan on channels not being measured.
    for (int k = 0; k < N; k++) dly[k] = $urandom_range(0, 25);
    rnd_mut = 1'b1;
    repeat (6) wait_done(400);
    rnd_mut = 1'b0;

    // Reset pulse during channel 2 measurement.
    set_dly(3, 4, 15, 2);
    t = 0;
    do begin
      step();
      t++;
    end while (!(busy && active_ch == 2'd2 && sensor_drive == '0) && t < 400);
    chk("reach_ch2_measure", 64'(active_ch), 64'(2));
    reset = 1'b0;
    step();
    chk("mid_rst_drive", 64'(sensor_drive), 64'(0));
    chk("mid_rst_time", 64'(time_bus != '0), 64'(0));
    chk("mid_rst_black", 64'(black), 64'(0));
    chk("mid_rst_done", 64'(scan_done), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ch", 64'(active_ch), 64'(0));
    reset = 1'b1;
    step();
    chk("restart_ch0", 64'(sensor_drive), 64'(1));
    wait_done(400);
    chk_times("after_rst", 5, 6, 17, 4);

    // Drop enable during channel 1 charge: scan completes, then idle.
    t = 0;
    do begin
      step();
      t++;
    end while (!sensor_drive[1] && t < 400);
    chk("reach_ch1_charge", 64'(sensor_drive), 64'(4'b0010));
    enable = 1'b0;
    wait_done(400);
    chk_times("drop_en", 5, 6, 17, 4);
    extra = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (scan_done) extra++;
      if (busy || sensor_drive != '0) chk("idle_quiet", 64'({busy, sensor_drive}), 64'(0));
    end
    chk("extra_done", 64'(extra), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_drive", 64'(sensor_drive), 64'(0));
    chk_times("idle_hold", 5, 6, 17, 4);

    // Restart from idle.
    set_dly(8, 1, 22, 0);
    enable = 1'b1;
    step();
    chk("enable_to_drive2", 64'(sensor_drive), 64'(1));
    wait_done(400);
    chk_times("restart", 10, 3, 20, 2);
    chk("restart_black", 64'(black), 64'(4'b0100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
